// File: rtl/led_pwm_if.sv
// LED driver control/status bundle: settings in from the register side,
// LED drive and status out toward the board.
interface led_pwm_if #(
  parameter int NUM_LEDS = 8,
  parameter int PWM_BITS = 8
);
  logic [NUM_LEDS-1:0] data;
  logic [PWM_BITS-1:0] brightness;
  logic [1:0]          mode;
  logic                load;
  logic [NUM_LEDS-1:0] leds;
  logic                update_pending;
  logic                period_start;

  modport master (
    output data, brightness, mode, load,
    input  leds, update_pending, period_start
  );

  modport slave (
    input  data, brightness, mode, load,
    output leds, update_pending, period_start
  );
endinterface

// File: rtl/led_pwm_driver.sv
// Parametrised LED bank driver: on/off data, global PWM brightness and blink.
// Settings are double-buffered and only switch over at a PWM period boundary,
// so a reconfiguration never produces a partial period on the pins.

// One LED output register.
module led_pwm_lane (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic gate,
  output logic led
);
  // Registered drive: channel enable qualified by the shared PWM/blink gate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) led <= 1'b0;
    else     led <= en & gate;
  end
endmodule

module led_pwm_driver #(
  parameter int NUM_LEDS      = 8,
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE      = 4,
  parameter int BLINK_PERIODS = 64
) (
  input  logic     clk,
  input  logic     rst,
  led_pwm_if.slave bus
);
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BL_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);
  localparam logic [BL_W-1:0] BL_MAX = BL_W'(BLINK_PERIODS - 1);

  typedef struct packed {
    logic [NUM_LEDS-1:0] data;
    logic [PWM_BITS-1:0] brightness;
    logic [1:0]          mode;
  } cfg_t;

  cfg_t                in_cfg, shadow, active;
  logic                pending;
  logic [PS_W-1:0]     prescaler;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [BL_W-1:0]     blink_cnt;
  logic                blink_phase;
  logic                period_q;
  logic                tick, boundary;
  logic                pwm_on, blink_on, gate;
  logic [NUM_LEDS-1:0] leds_q;

  assign in_cfg   = '{data: bus.data, brightness: bus.brightness, mode: bus.mode};
  assign tick     = (prescaler == PS_MAX);
  assign boundary = tick && (pwm_cnt == '1);

  // Prescaler: one PWM step every PRESCALE clocks
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       prescaler <= '0;
    else if (tick) prescaler <= '0;
    else           prescaler <= prescaler + PS_W'(1);
  end

  // PWM counter free-runs and wraps naturally at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       pwm_cnt <= '0;
    else if (tick) pwm_cnt <= pwm_cnt + PWM_BITS'(1);
  end

  // period_start marks the clock on which pwm_cnt has just become 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) period_q <= 1'b0;
    else     period_q <= boundary;
  end

  // Shadow/active settings; a load landing on the boundary bypasses the shadow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else if (bus.load) begin
      shadow <= in_cfg;
      if (boundary) begin
        active  <= in_cfg;
        pending <= 1'b0;
      end else begin
        pending <= 1'b1;
      end
    end else if (boundary && pending) begin
      active  <= shadow;
      pending <= 1'b0;
    end
  end

  // Blink timebase counts whole periods; mode changes never disturb it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (boundary) begin
      if (blink_cnt == BL_MAX) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + BL_W'(1);
      end
    end
  end

  // mode[1] selects PWM dimming, mode[0] selects blinking; all-ones is solid on
  assign pwm_on   = !active.mode[1] || (pwm_cnt < active.brightness) ||
                    (active.brightness == '1);
  assign blink_on = !active.mode[0] || blink_phase;
  assign gate     = pwm_on & blink_on;

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_lane
    led_pwm_lane u_lane (
      .clk  (clk),
      .rst  (rst),
      .en   (active.data[i]),
      .gate (gate),
      .led  (leds_q[i])
    );
  end

  assign bus.leds           = leds_q;
  assign bus.update_pending = pending;
  assign bus.period_start   = period_q;
endmodule
